// File: rtl/sim_step_scheduler_if.sv
// Control and client handshake bundle for the simulation step scheduler.
// The scheduler takes the master view; the host and step clients take the slave view.
interface sim_step_scheduler_if #(
  parameter int DIV_WIDTH = 32,
  parameter int N_CLIENTS = 4,
  parameter int CNT_WIDTH = 32
);
  logic                 run_i;
  logic                 pause_i;
  logic                 stop_i;
  logic                 step_i;
  logic                 div_load_i;
  logic [DIV_WIDTH-1:0] div_value_i;
  logic                 clr_ovr_i;
  logic [N_CLIENTS-1:0] step_done_i;
  logic                 step_req_o;
  logic                 sim_clk_o;
  logic                 busy_o;
  logic                 overrun_o;
  logic [CNT_WIDTH-1:0] step_count_o;
  logic [1:0]           state_o;

  modport master (
    input  run_i, pause_i, stop_i, step_i, div_load_i, div_value_i, clr_ovr_i, step_done_i,
    output step_req_o, sim_clk_o, busy_o, overrun_o, step_count_o, state_o
  );

  modport slave (
    output run_i, pause_i, stop_i, step_i, div_load_i, div_value_i, clr_ovr_i, step_done_i,
    input  step_req_o, sim_clk_o, busy_o, overrun_o, step_count_o, state_o
  );
endinterface

// File: rtl/sim_step_scheduler.sv
// HIL simulation timebase: divides the system clock into step ticks, broadcasts a step
// strobe to all clients and withholds the next step until every client has acknowledged.
module sim_step_scheduler #(
  parameter int DIV_WIDTH   = 32,
  parameter int DEFAULT_DIV = 50000,
  parameter int N_CLIENTS   = 4,
  parameter int CNT_WIDTH   = 32
) (
  input logic                 CLK_50MHZ,
  input logic                 RST,
  sim_step_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] DIV_MIN   = DIV_WIDTH'(2);

  state_t               state, state_next;
  logic [DIV_WIDTH-1:0] presc;
  logic [DIV_WIDTH-1:0] div_reg;
  logic [DIV_WIDTH-1:0] div_clamped;
  logic [N_CLIENTS-1:0] pending;
  logic [CNT_WIDTH-1:0] step_count;
  logic                 step_req;
  logic                 sim_clk;
  logic                 overrun;
  logic                 tick;
  logic                 trigger;

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the case/if tree leaves a signal unassigned and infers a latch.
  always_comb begin
    state_next = state;
    if (bus.stop_i) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (bus.run_i) state_next = RUN;
        RUN:     if (bus.pause_i) state_next = PAUSE;
        PAUSE:   if (!bus.pause_i && bus.run_i) state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    tick        = (state == RUN) && (presc == div_reg - DIV_WIDTH'(1));
    trigger     = (pending == '0) &&
                  (tick || (bus.step_i && (state == IDLE || state == PAUSE)));
    div_clamped = (bus.div_value_i < DIV_MIN) ? DIV_MIN : bus.div_value_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order within the block.
  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      state      <= IDLE;
      presc      <= '0;
      div_reg    <= DIV_RESET;
      pending    <= '0;
      step_count <= '0;
      step_req   <= 1'b0;
      sim_clk    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state <= state_next;

      // Pause holds the prescaler so that resuming keeps the step phase.
      if (bus.stop_i || state == IDLE)
        presc <= '0;
      else if (state == RUN)
        presc <= tick ? '0 : presc + DIV_WIDTH'(1);

      if (state == IDLE && bus.div_load_i)
        div_reg <= div_clamped;

      step_req <= trigger;
      if (trigger) begin
        pending    <= '1;
        step_count <= step_count + CNT_WIDTH'(1);
        sim_clk    <= ~sim_clk;
      end else if (!step_req) begin
        // Acks coinciding with the strobe are dropped; the fresh pending set wins.
        pending <= pending & ~bus.step_done_i;
      end

      if (tick && pending != '0)
        overrun <= 1'b1;
      else if (bus.clr_ovr_i)
        overrun <= 1'b0;
    end
  end

  assign bus.step_req_o   = step_req;
  assign bus.sim_clk_o    = sim_clk;
  assign bus.busy_o       = |pending;
  assign bus.overrun_o    = overrun;
  assign bus.step_count_o = step_count;
  assign bus.state_o      = state;

endmodule

// File: tb/tb_sim_step_scheduler.sv
// Directed bench for sim_step_scheduler: free run, overrun, pause/single-step,
// divider clamping and locking, control priority, counter wrap and reset mid-step.
module tb_sim_step_scheduler;

  localparam int DIV_WIDTH = 32;
  localparam int N_CLIENTS = 4;
  localparam int CNT_WIDTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   n;

  sim_step_scheduler_if #(
    .DIV_WIDTH(DIV_WIDTH), .N_CLIENTS(N_CLIENTS), .CNT_WIDTH(CNT_WIDTH)
  ) bus ();

  sim_step_scheduler #(
    .DIV_WIDTH(DIV_WIDTH), .DEFAULT_DIV(50000), .N_CLIENTS(N_CLIENTS), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .CLK_50MHZ(clk),
    .RST      (rst),
    .bus      (bus)
  );

  always #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clock edges; returns 1 time unit after the last edge.
  task automatic cyc(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
  endtask

  task automatic load_div(input logic [DIV_WIDTH-1:0] v);
    bus.div_load_i  = 1'b1;
    bus.div_value_i = v;
    cyc(1);
    bus.div_load_i  = 1'b0;
  endtask

  task automatic pulse_run();
    bus.run_i = 1'b1;
    cyc(1);
    bus.run_i = 1'b0;
  endtask

  task automatic wait_req(input int max_cycles, output int waited);
    waited = 0;
    while (bus.step_req_o !== 1'b1 && waited < max_cycles) begin
      cyc(1);
      waited++;
    end
  endtask

  initial begin
    bus.run_i       = 1'b0;
    bus.pause_i     = 1'b0;
    bus.stop_i      = 1'b0;
    bus.step_i      = 1'b0;
    bus.div_load_i  = 1'b0;
    bus.div_value_i = '0;
    bus.clr_ovr_i   = 1'b0;
    bus.step_done_i = '0;

    // Reset state
    cyc(3);
    check("rst_step_req", bus.step_req_o, 0);
    check("rst_sim_clk",  bus.sim_clk_o, 0);
    check("rst_busy",     bus.busy_o, 0);
    check("rst_overrun",  bus.overrun_o, 0);
    check("rst_count",    bus.step_count_o, 0);
    check("rst_state",    bus.state_o, 0);
    check("rst_div_reg",  dut.div_reg, 50000);
    rst = 1'b0;

    // Free run, div=4, all clients ack two cycles after each strobe
    load_div(4);
    pulse_run();
    check("run_state", bus.state_o, 1);
    wait_req(10, n);
    check("run_first_latency", n, 4);
    for (int i = 1; i <= 4; i++) begin
      check("run_req",     bus.step_req_o, 1);
      check("run_count",   bus.step_count_o, i);
      check("run_sim_clk", bus.sim_clk_o, i % 2);
      cyc(1);
      check("run_req_width", bus.step_req_o, 0);
      cyc(1);
      bus.step_done_i = 4'hF;
      cyc(1);
      bus.step_done_i = '0;
      check("run_busy_drop", bus.busy_o, 0);
      cyc(1);
    end
    check("run_req5", bus.step_req_o, 1);
    bus.stop_i = 1'b1;
    cyc(1);
    bus.stop_i = 1'b0;
    check("stop_state",     bus.state_o, 0);
    check("stop_keeps_busy", bus.busy_o, 1);
    check("stop_count",     bus.step_count_o, 5);

    // Overrun: client 2 withholds its ack
    do_reset();
    load_div(4);
    pulse_run();
    wait_req(10, n);
    check("ovr_first_req", bus.step_req_o, 1);
    check("ovr_count1",    bus.step_count_o, 1);
    cyc(2);
    bus.step_done_i = 4'b1011;
    cyc(1);
    bus.step_done_i = '0;
    check("ovr_busy_held",  bus.busy_o, 1);
    check("ovr_pre_tick",   bus.overrun_o, 0);
    cyc(1);
    check("ovr_set",        bus.overrun_o, 1);
    check("ovr_no_req",     bus.step_req_o, 0);
    cyc(3);
    bus.clr_ovr_i = 1'b1;
    cyc(1);
    bus.clr_ovr_i = 1'b0;
    check("ovr_set_wins",   bus.overrun_o, 1);
    check("ovr_count_hold", bus.step_count_o, 1);
    bus.clr_ovr_i   = 1'b1;
    bus.step_done_i = 4'b0100;
    cyc(1);
    bus.clr_ovr_i   = 1'b0;
    bus.step_done_i = '0;
    check("ovr_cleared",    bus.overrun_o, 0);
    check("ovr_busy_clear", bus.busy_o, 0);
    wait_req(8, n);
    check("ovr_resume_lat", n, 3);
    check("ovr_count2",     bus.step_count_o, 2);

    // Pause at prescaler 6 with div=10, two single steps, then resume
    do_reset();
    load_div(10);
    pulse_run();
    cyc(6);
    bus.pause_i = 1'b1;
    cyc(1);
    bus.pause_i = 1'b0;
    check("pause_state", bus.state_o, 2);
    bus.step_i = 1'b1;
    cyc(1);
    bus.step_i = 1'b0;
    check("step1_req",   bus.step_req_o, 1);
    check("step1_count", bus.step_count_o, 1);
    cyc(1);
    bus.step_i = 1'b1;
    cyc(1);
    bus.step_i = 1'b0;
    check("step_busy_ignored", bus.step_req_o, 0);
    check("step_busy_no_ovr",  bus.overrun_o, 0);
    bus.step_done_i = 4'hF;
    cyc(1);
    bus.step_done_i = '0;
    bus.step_i = 1'b1;
    cyc(1);
    bus.step_i = 1'b0;
    check("step2_req",   bus.step_req_o, 1);
    check("step2_count", bus.step_count_o, 2);
    cyc(1);
    bus.step_done_i = 4'hF;
    cyc(1);
    bus.step_done_i = '0;
    pulse_run();
    check("resume_state", bus.state_o, 1);
    bus.step_i = 1'b1;
    cyc(1);
    bus.step_i = 1'b0;
    check("step_in_run_ignored", bus.step_req_o, 0);
    cyc(1);
    check("resume_no_req_yet", bus.step_req_o, 0);
    cyc(1);
    check("resume_phase_req", bus.step_req_o, 1);
    check("resume_count",     bus.step_count_o, 3);

    // Divider 1 clamps to 2
    do_reset();
    load_div(1);
    check("clamp_div_reg", dut.div_reg, 2);
    pulse_run();
    wait_req(10, n);
    check("clamp_latency", n, 2);

    // Divider load in RUN is ignored
    do_reset();
    load_div(4);
    pulse_run();
    load_div(8);
    wait_req(10, n);
    check("runload_latency", n, 3);
    cyc(1);
    bus.step_done_i = 4'hF;
    cyc(1);
    bus.step_done_i = '0;
    wait_req(10, n);
    check("runload_period", n, 2);

    // pause_i and run_i together
    bus.pause_i = 1'b1;
    bus.run_i   = 1'b1;
    cyc(1);
    check("both_in_run", bus.state_o, 2);
    cyc(1);
    check("both_in_pause", bus.state_o, 2);
    bus.pause_i = 1'b0;
    cyc(1);
    bus.run_i = 1'b0;
    check("run_from_pause", bus.state_o, 1);

    // Counter wrap with a 4-bit step counter; first ack lands in the strobe cycle
    do_reset();
    bus.step_i = 1'b1;
    cyc(1);
    bus.step_i = 1'b0;
    bus.step_done_i = 4'hF;
    cyc(1);
    check("ack_in_req_cycle_ignored", bus.busy_o, 1);
    cyc(1);
    bus.step_done_i = '0;
    check("ack_after_req", bus.busy_o, 0);
    for (int i = 0; i < 16; i++) begin
      bus.step_i = 1'b1;
      cyc(1);
      bus.step_i = 1'b0;
      cyc(1);
      bus.step_done_i = 4'hF;
      cyc(1);
      bus.step_done_i = '0;
    end
    check("wrap_count", bus.step_count_o, 1);

    // Reset while busy discards outstanding acks
    bus.step_i = 1'b1;
    cyc(1);
    bus.step_i = 1'b0;
    check("pre_rst_busy", bus.busy_o, 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("rst_mid_busy",  bus.busy_o, 0);
    check("rst_mid_count", bus.step_count_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
